cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- Sequencing FSM for the set-associative cache datapath.
- Takes CPU-side read/write requests and runs each one as hit compare, optional dirty writeback, and line allocate.
- Drives every per-way load strobe, both datapath mux selects and the pseudo-LRU update, and handshakes with physical memory for 256-bit line transfers.
- One instance per cache; sits between the datapath and the CPU/memory arbiter ports.

Parameters:
- num_ways, 2, log2 of associativity; legal values 1..3 (2, 4 or 8 ways).
- way_number, 2**num_ways, derived number of ways; localparam only.

Ports:
- clk  in  1  clock
- rst  in  1  active-low synchronous reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_resp  in  1  memory completion, single cycle
- hit  in  1  datapath tag match
- hit_path  in  num_ways  matching way index
- lru_dirty_bit  in  1  dirty bit of victim way
- lru_valid_bit  in  1  valid bit of victim way
- lru_path  in  num_ways  victim way index
- lru_output  in  way_number-1  current PLRU tree bits of the set
- lru_input  out  way_number-1  new PLRU tree bits
- load_lru  out  1  PLRU array write strobe
- load_tag_array, load_valid_array, load_data_array, load_dirty_array  out  way_number  per-way write strobes
- dirty_input_array  out  way_number  per-way dirty value written
- addr_bit  out  1  pmem address select: 0 = CPU line address, 1 = victim tag address
- data_bit  out  1  data-in select: 0 = CPU wdata with byte enables, 1 = pmem line

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Encoding lives in the package.
- Default output values in every state: all strobes 0, dirty_input_array 0, addr_bit 0, data_bit 0, mem_resp 0, pmem_read 0, pmem_write 0, lru_input = lru_output.
- Reset (rst==0 at a clk edge): state becomes IDLE; all outputs at their defaults on the next cycle. Reset mid-transfer drops pmem_read/pmem_write immediately; the in-flight pmem_resp is ignored.
- IDLE:
  - mem_read or mem_write high → COMPARE next cycle. This cycle lets the synchronous arrays present the set.
  - No request → stay in IDLE.
- COMPARE, hit==1:
  - Read: mem_resp=1, load_lru=1, lru_input=PLRU update of hit_path → IDLE.
  - Write: additionally load_data_array[hit_path]=1, data_bit=0, load_dirty_array[hit_path]=1, dirty_input_array[hit_path]=1 → IDLE.
  - Hit latency: 2 cycles from request to mem_resp.
- COMPARE, hit==0:
  - lru_valid_bit && lru_dirty_bit → WRITEBACK.
  - Otherwise → ALLOCATE.
  - No LRU update on a miss.
- WRITEBACK: addr_bit=1, pmem_write=1. On pmem_resp → ALLOCATE.
- ALLOCATE: addr_bit=0, pmem_read=1. On pmem_resp, in the same cycle:
  - data_bit=1.
  - Strobe load_data_array, load_tag_array, load_valid_array and load_dirty_array at index lru_path.
  - dirty_input_array[lru_path]=0.
  - → COMPARE, where the re-lookup hits and completes the request as a normal hit.
- lru_path stays stable between COMPARE and ALLOCATE because load_lru is 0 on misses.
- PLRU update for accessed way w:
  - Root bit lru[0] = ~w[msb].
  - Each lower level writes the complement of the next bit of w into the node selected by the upper bits of w, in heap order (node 1 is the left child of the root, node 2 the right child, and so on).
  - Untouched nodes keep their value.
  - num_ways=1: lru_input = ~w.
- mem_read and mem_write both high: treated as a write.
- A request that drops before mem_resp is illegal; behaviour is undefined, and an assertion flags it.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs hit_count, miss_count, writeback_count. Reset to 0; wrap at 2**32.
  - hit_count increments on each mem_resp whose request first hit in COMPARE.
  - miss_count increments on each COMPARE→WRITEBACK or COMPARE→ALLOCATE transition.
  - writeback_count increments on each pmem_resp in WRITEBACK.
- Undefined: the ports and counters are absent; FSM behaviour is identical.

Decomposition:
- Package cache_ctrl_pkg: state enum typedef cache_state_t, constants ADDR_SEL_CPU/ADDR_SEL_VICTIM and DATA_SEL_CPU/DATA_SEL_PMEM.
- Sub-module plru_update (parameter num_ways; inputs lru_output and way; output lru_input), purely combinational.
- FSM, strobe decode and the optional counters stay in cache_control.

Test Plan:
- Reset with rst=0 for 2 cycles → all outputs 0, state IDLE; a request held during reset gets no mem_resp until 2 cycles after rst=1.
- Read miss to a clean set (num_ways=2, lru_output=3'b000, lru_path=0) → ALLOCATE with pmem_read=1 and addr_bit=0. On pmem_resp: data_bit=1 and strobes on way 0. Re-COMPARE hits; mem_resp pulses exactly once; lru_input=3'b011.
- Write hit on way 3 with lru_output=3'b000 → 2 cycles later: mem_resp=1, load_data_array=4'b1000, dirty_input_array[3]=1, data_bit=0, lru_input=3'b000.
- Dirty victim (lru_valid_bit=1, lru_dirty_bit=1) → WRITEBACK with pmem_write=1 and addr_bit=1 held for 5 cycles until pmem_resp, then ALLOCATE, then hit; total 1 mem_resp.
- rst=0 asserted during ALLOCATE → next cycle pmem_read=0, IDLE; a late pmem_resp causes no strobes.
- CACHE_PERF_CNT_EN: 3 hits, 1 clean miss, 1 dirty miss → hit_count=3, miss_count=2, writeback_count=1.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and datapath mux select values for the cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } cache_state_t;

  localparam logic ADDR_SEL_CPU    = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;
  localparam logic DATA_SEL_CPU    = 1'b0;
  localparam logic DATA_SEL_PMEM   = 1'b1;

endpackage

// File: rtl/plru_update.sv
// Tree pseudo-LRU update: marks the accessed way as most recently used by
// pointing every node on its root-to-leaf path away from it.
module plru_update #(
  parameter int num_ways = 2,
  localparam int way_number = 2 ** num_ways
) (
  input  logic [way_number-2:0] lru_output,
  input  logic [num_ways-1:0]   way,
  output logic [way_number-2:0] lru_input
);

  always_comb begin
    lru_input = lru_output;
    // Level l nodes start at heap index 2**l-1; the upper l bits of way pick the node.
    for (int l = 0; l < num_ways; l++) begin
      for (int n = 0; n < way_number - 1; n++) begin
        if (n == (2 ** l) - 1 + (int'(way) >> (num_ways - l)))
          lru_input[n] = ~way[num_ways-1-l];
      end
    end
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the set-associative cache: compare, writeback, allocate.
// Optional performance counters are enabled with the CACHE_PERF_CNT_EN macro.
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int num_ways = 2,
  localparam int way_number = 2 ** num_ways
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  input  logic                  hit,
  input  logic [num_ways-1:0]   hit_path,
  input  logic                  lru_dirty_bit,
  input  logic                  lru_valid_bit,
  input  logic [num_ways-1:0]   lru_path,
  input  logic [way_number-2:0] lru_output,
  output logic [way_number-2:0] lru_input,
  output logic                  load_lru,
  output logic [way_number-1:0] load_tag_array,
  output logic [way_number-1:0] load_valid_array,
  output logic [way_number-1:0] load_data_array,
  output logic [way_number-1:0] load_dirty_array,
  output logic [way_number-1:0] dirty_input_array,
  output logic                  addr_bit,
  output logic                  data_bit
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           writeback_count
`endif
);

  cache_state_t          state;
  logic                  victim_dirty;
  logic [way_number-1:0] hit_oh;
  logic [way_number-1:0] lru_oh;
  logic [way_number-2:0] plru_next;

  assign victim_dirty = lru_valid_bit & lru_dirty_bit;
  assign hit_oh       = way_number'(1) << hit_path;
  assign lru_oh       = way_number'(1) << lru_path;

  plru_update #(.num_ways(num_ways)) u_plru (
    .lru_output(lru_output),
    .way       (hit_path),
    .lru_input (plru_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (mem_read | mem_write) state <= COMPARE;
        COMPARE: begin
          if (hit)               state <= IDLE;
          else if (victim_dirty) state <= WRITEBACK;
          else                   state <= ALLOCATE;
        end
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE:  if (pmem_resp) state <= COMPARE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Strobes react to hit/pmem_resp in the same cycle so the arrays load on time.
  always_comb begin
    mem_resp          = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    load_lru          = 1'b0;
    lru_input         = lru_output;
    load_tag_array    = '0;
    load_valid_array  = '0;
    load_data_array   = '0;
    load_dirty_array  = '0;
    dirty_input_array = '0;
    addr_bit          = ADDR_SEL_CPU;
    data_bit          = DATA_SEL_CPU;
    case (state)
      COMPARE: begin
        if (hit) begin
          mem_resp  = 1'b1;
          load_lru  = 1'b1;
          lru_input = plru_next;
          if (mem_write) begin
            load_data_array   = hit_oh;
            load_dirty_array  = hit_oh;
            dirty_input_array = hit_oh;
          end
        end
      end
      WRITEBACK: begin
        addr_bit   = ADDR_SEL_VICTIM;
        pmem_write = 1'b1;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_bit         = DATA_SEL_PMEM;
          load_data_array  = lru_oh;
          load_tag_array   = lru_oh;
          load_valid_array = lru_oh;
          load_dirty_array = lru_oh;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic req_missed;

  // A request that missed once finishes with a hit on re-lookup; that is not a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
      req_missed      <= 1'b0;
    end else begin
      if (state == IDLE) req_missed <= 1'b0;
      if (state == COMPARE && hit && !req_missed) hit_count <= hit_count + 32'd1;
      if (state == COMPARE && !hit) begin
        miss_count <= miss_count + 32'd1;
        req_missed <= 1'b1;
      end
      if (state == WRITEBACK && pmem_resp) writeback_count <= writeback_count + 32'd1;
    end
  end
`endif

  req_held: assert property (@(posedge clk) disable iff (!rst)
    (state != IDLE) |-> (mem_read | mem_write));

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control with a transaction-level model.
module tb_cache_control;
  localparam int NW = 2;
  localparam int WN = 2 ** NW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0, hit = 1'b0;
  logic          mem_resp, pmem_read, pmem_write, load_lru, addr_bit, data_bit;
  logic [NW-1:0] hit_path = '0, lru_path = '0;
  logic          lru_dirty_bit = 1'b0, lru_valid_bit = 1'b0;
  logic [WN-2:0] lru_output = '0, lru_input;
  logic [WN-1:0] load_tag_array, load_valid_array, load_data_array, load_dirty_array;
  logic [WN-1:0] dirty_input_array;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]   hit_count, miss_count, writeback_count;
`endif

  cache_control #(.num_ways(NW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit(hit), .hit_path(hit_path), .lru_dirty_bit(lru_dirty_bit),
    .lru_valid_bit(lru_valid_bit), .lru_path(lru_path), .lru_output(lru_output),
    .lru_input(lru_input), .load_lru(load_lru), .load_tag_array(load_tag_array),
    .load_valid_array(load_valid_array), .load_data_array(load_data_array),
    .load_dirty_array(load_dirty_array), .dirty_input_array(dirty_input_array),
    .addr_bit(addr_bit), .data_bit(data_bit)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem_resp, pmem_read, pmem_write, addr_bit, data_bit, load_lru;
    logic [WN-2:0] lru_in;
    logic [WN-1:0] ld_tag, ld_valid, ld_data, ld_dirty, dirty_in;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, passes = 0;
  int  hits_m = 0, miss_m = 0, wb_m = 0;
  bit  auto_resp = 1'b1;
  int  wb_lat = 1, fill_lat = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic ev_t blank(input logic [WN-2:0] lo);
    ev_t e;
    e = '0;
    e.lru_in = lo;
    return e;
  endfunction

  function automatic logic [WN-1:0] oh(input logic [NW-1:0] w);
    return WN'(1) << w;
  endfunction

  // Walk from the root toward the accessed leaf, pointing each visited node away.
  function automatic logic [WN-2:0] model_plru(input logic [WN-2:0] lo, input logic [NW-1:0] w);
    logic [WN-2:0] r, m;
    logic [NW-1:0] s;
    int            node;
    r = lo;
    node = 0;
    for (int lvl = NW - 1; lvl >= 0; lvl--) begin
      s = w >> lvl;
      m = (WN-1)'(1) << node;
      r = s[0] ? (r & ~m) : (r | m);
      node = 2 * node + 1 + (s[0] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic ev_t cur_ev();
    ev_t e;
    e.mem_resp = mem_resp;   e.pmem_read = pmem_read; e.pmem_write = pmem_write;
    e.addr_bit = addr_bit;   e.data_bit = data_bit;   e.load_lru = load_lru;
    e.lru_in   = lru_input;  e.ld_tag = load_tag_array; e.ld_valid = load_valid_array;
    e.ld_data  = load_data_array; e.ld_dirty = load_dirty_array;
    e.dirty_in = dirty_input_array;
    return e;
  endfunction

  // Monitor: any visible action must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk); #1;
      if (rst === 1'b1 && (mem_resp || load_lru || (|load_tag_array) || (|load_valid_array) ||
          (|load_data_array) || (|load_dirty_array) || (|dirty_input_array) ||
          (pmem_resp && (pmem_read || pmem_write)))) begin
        if (exp_q.size() == 0) chk("unexpected_event", 64'(cur_ev()), 64'(blank(lru_output)));
        else begin
          e = exp_q.pop_front();
          chk("event", 64'(cur_ev()), 64'(e));
        end
      end
    end
  end

  // Memory and datapath responder.
  initial begin
    int cnt;
    bit fill_pending;
    cnt = 0;
    fill_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_resp) begin
        if (pmem_resp && fill_pending) begin
          hit = 1'b1;
          hit_path = lru_path;
        end
        pmem_resp = 1'b0;
        fill_pending = 1'b0;
        if (rst === 1'b1 && (pmem_read === 1'b1 || pmem_write === 1'b1)) begin
          cnt++;
          if (cnt >= (pmem_write ? wb_lat : fill_lat)) begin
            pmem_resp = 1'b1;
            fill_pending = pmem_read;
            cnt = 0;
          end
        end else cnt = 0;
      end else cnt = 0;
    end
  end

  task automatic issue(input int op, input bit hi, input logic [NW-1:0] hp, input logic [NW-1:0] lp,
                       input logic [WN-2:0] lo, input bit v, input bit d, input int lw, input int lf,
                       input bit push, output int lat);
    ev_t           e;
    logic [NW-1:0] w;
    bit            wr;
    wr = (op != 0);
    wb_lat = lw;
    fill_lat = lf;
    mem_read = (op != 1);
    mem_write = wr;
    hit = hi; hit_path = hp; lru_path = lp; lru_output = lo;
    lru_valid_bit = v; lru_dirty_bit = d;
    w = hi ? hp : lp;
    lat = 1;
    if (!hi) begin
      miss_m++;
      if (v && d) begin
        wb_m++;
        lat += lw;
        e = blank(lo); e.pmem_write = 1'b1; e.addr_bit = 1'b1;
        if (push) exp_q.push_back(e);
      end
      lat += lf + 1;
      e = blank(lo); e.pmem_read = 1'b1; e.data_bit = 1'b1;
      e.ld_tag = oh(lp); e.ld_valid = oh(lp); e.ld_data = oh(lp); e.ld_dirty = oh(lp);
      if (push) exp_q.push_back(e);
    end else hits_m++;
    e = blank(lo); e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = model_plru(lo, w);
    if (wr) begin
      e.ld_data = oh(w); e.ld_dirty = oh(w); e.dirty_in = oh(w);
    end
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_resp(input string nm, input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk); #1;
      n++;
      seen = (mem_resp === 1'b1);
    end
    chk(nm, 64'(n), 64'(lat));
  endtask

  task automatic run_txn(input string nm, input int op, input bit hi, input logic [NW-1:0] hp,
                         input logic [NW-1:0] lp, input logic [WN-2:0] lo, input bit v, input bit d,
                         input int lw, input int lf);
    int lat;
    issue(op, hi, hp, lp, lo, v, d, lw, lf, 1'b1, lat);
    wait_resp(nm, lat);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, n;
    int op, lw, lf;
    bit hi, v, d;
    logic [NW-1:0] hp, lp;
    logic [WN-2:0] lo;

    // Request held through reset: nothing happens until reset is released.
    @(negedge clk);
    issue(0, 1'b1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 1, 1, 1'b1, lat);
    #1 chk("reset_outputs", 64'(cur_ev()), 64'(blank(3'b000)));
    @(negedge clk);
    rst = 1'b1;
    wait_resp("reset_release_latency", lat);
    @(negedge clk);
    mem_read = 1'b0; hit = 1'b0;

    run_txn("clean_read_miss", 0, 1'b0, 2'd1, 2'd0, 3'b000, 1'b0, 1'b0, 1, 3);
    run_txn("write_hit_way3", 1, 1'b1, 2'd3, 2'd0, 3'b000, 1'b0, 1'b0, 1, 1);
    run_txn("dirty_victim", 0, 1'b0, 2'd0, 2'd2, 3'b101, 1'b1, 1'b1, 5, 2);
    run_txn("both_req_write", 2, 1'b1, 2'd1, 2'd3, 3'b111, 1'b1, 1'b1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      hi = 1'($urandom_range(0, 1));
      hp = NW'($urandom_range(0, WN - 1));
      lp = NW'($urandom_range(0, WN - 1));
      lo = (WN-1)'($urandom_range(0, 2 ** (WN - 1) - 1));
      v  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      lw = int'($urandom_range(1, 6));
      lf = int'($urandom_range(1, 6));
      run_txn("random_latency", op, hi, hp, lp, lo, v, d, lw, lf);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while a line fill is outstanding.
    auto_resp = 1'b0;
    issue(0, 1'b0, 2'd0, 2'd1, 3'b010, 1'b0, 1'b0, 1, 1, 1'b0, lat);
    n = 0;
    while (pmem_read !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("alloc_reached", 64'(pmem_read), 64'(1));
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; hit = 1'b0;
    @(negedge clk); #1;
    chk("reset_drops_pmem_read", 64'(cur_ev()), 64'(blank(3'b010)));
    @(negedge clk);
    rst = 1'b1; pmem_resp = 1'b1;
    #1 chk("late_pmem_resp_ignored", 64'(cur_ev()), 64'(blank(3'b010)));
    @(negedge clk);
    pmem_resp = 1'b0; auto_resp = 1'b1;

    run_txn("after_abort_miss", 1, 1'b0, 2'd2, 2'd3, 3'b001, 1'b1, 1'b1, 2, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", 64'(hit_count), 64'(hits_m));
    chk("miss_count", 64'(miss_count), 64'(miss_m));
    chk("writeback_count", 64'(writeback_count), 64'(wb_m));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
